// File: rtl/griffin_stream_ctrl.sv
// Stream bridge for griffin_top: load 3x39 words, run until done, drain results through a 2-entry FIFO.
// Optional CANON_CHECK_EN: err_noncanon latches when an accepted word is >= PRIME_MODULUS.
module griffin_stream_ctrl #(
    parameter int unsigned        N_BITS         = 254,
    parameter logic [N_BITS-1:0]  PRIME_MODULUS  = {2'b11, 252'h0644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001},
    parameter int unsigned        LANES          = 3,
    parameter int unsigned        WORDS_PER_LANE = 39
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [N_BITS-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [N_BITS-1:0] m_data,
    output logic              g_reset,
    output logic              g_enable,
    output logic [LANES-1:0]  g_wr,
    output logic [LANES-1:0]  g_rd,
    output logic [N_BITS-1:0] g_in_state,
    input  logic [N_BITS-1:0] g_out_state,
    input  logic              g_done,
    output logic              busy,
    output logic              err_noncanon
);
    localparam int LW = $clog2(LANES);
    localparam int WW = $clog2(WORDS_PER_LANE);

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, RUN, DRAIN} state_t;

    state_t              r_state;
    logic [LW-1:0]       r_lane;
    logic [WW-1:0]       r_word;
    logic                r_s_ready;
    logic                r_g_reset;
    logic                r_g_enable;
    logic [LANES-1:0]    r_g_wr;
    logic [N_BITS-1:0]   r_g_in_state;
    logic                r_issue_done;
    logic                r_inflight;
    logic [1:0]          r_occ;
    logic                r_wptr;
    logic                r_rptr;
    logic [N_BITS-1:0]   r_fifo [2];

    logic [LANES-1:0]    w_lane_oh;
    logic [LW-1:0]       w_lane_nxt;
    logic [WW-1:0]       w_word_nxt;
    logic                w_last;
    logic                w_in_hs;
    logic                w_pop;
    logic [2:0]          w_pending;
    logic                w_issue;

    assign w_lane_oh = LANES'(1) << r_lane;
    assign w_last    = (r_lane == LW'(LANES-1)) && (r_word == WW'(WORDS_PER_LANE-1));
    assign w_in_hs   = s_valid && r_s_ready;
    assign w_pop     = (r_occ != 2'd0) && m_ready;

    always_comb begin
        w_word_nxt = r_word + WW'(1);
        w_lane_nxt = r_lane;
        if (r_word == WW'(WORDS_PER_LANE-1)) begin
            w_word_nxt = '0;
            w_lane_nxt = r_lane + LW'(1);
        end
    end

    // A slot freed by this cycle's pop counts as free, which sustains one word per cycle.
    assign w_pending = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue   = (r_state == DRAIN) && !r_issue_done && (w_pending < 3'd2);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_lane       <= '0;
            r_word       <= '0;
            r_s_ready    <= 1'b0;
            r_g_reset    <= 1'b1;
            r_g_enable   <= 1'b0;
            r_g_wr       <= '0;
            r_g_in_state <= '0;
            r_issue_done <= 1'b0;
        end else begin
            r_g_reset <= 1'b0;
            r_g_wr    <= '0;
            case (r_state)
                IDLE: begin
                    if (s_valid) begin
                        r_state   <= CLEAR;
                        r_g_reset <= 1'b1;
                    end
                end
                CLEAR: begin
                    r_state   <= LOAD;
                    r_s_ready <= 1'b1;
                    r_lane    <= '0;
                    r_word    <= '0;
                end
                LOAD: begin
                    if (w_in_hs) begin
                        r_g_in_state <= s_data;
                        r_g_wr       <= w_lane_oh;
                        if (w_last) begin
                            r_state    <= RUN;
                            r_s_ready  <= 1'b0;
                            r_g_enable <= 1'b1;
                            r_lane     <= '0;
                            r_word     <= '0;
                        end else begin
                            r_lane <= w_lane_nxt;
                            r_word <= w_word_nxt;
                        end
                    end
                end
                RUN: begin
                    if (g_done) begin
                        r_state      <= DRAIN;
                        r_g_enable   <= 1'b0;
                        r_issue_done <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (w_issue) begin
                        if (w_last) begin
                            r_issue_done <= 1'b1;
                            r_lane       <= '0;
                            r_word       <= '0;
                        end else begin
                            r_lane <= w_lane_nxt;
                            r_word <= w_word_nxt;
                        end
                    end
                    if (r_issue_done && (r_occ == 2'd0) && !r_inflight)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // r_inflight marks the cycle in which g_out_state carries the word requested last cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inflight <= 1'b0;
            r_occ      <= 2'd0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_fifo[0]  <= '0;
            r_fifo[1]  <= '0;
        end else begin
            r_inflight <= w_issue;
            if (r_inflight) begin
                r_fifo[r_wptr] <= g_out_state;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop)
                r_rptr <= ~r_rptr;
            r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

`ifdef CANON_CHECK_EN
    logic r_err;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_err <= 1'b0;
        else if (w_in_hs && (s_data >= PRIME_MODULUS))
            r_err <= 1'b1;
    end
    assign err_noncanon = r_err;
`else
    assign err_noncanon = 1'b0;
`endif

    assign s_ready    = r_s_ready;
    assign m_valid    = (r_occ != 2'd0);
    assign m_data     = r_fifo[r_rptr];
    assign g_reset    = r_g_reset;
    assign g_enable   = r_g_enable;
    assign g_wr       = r_g_wr;
    assign g_rd       = w_issue ? w_lane_oh : '0;
    assign g_in_state = r_g_in_state;
    assign busy       = (r_state != IDLE);
endmodule

// File: tb/tb_griffin_stream_ctrl.sv
// Bench for griffin_stream_ctrl: reset/start vector table, then whole batches against a queue-based core model.
module tb_griffin_stream_ctrl;
    localparam int NB = 254;
    localparam int NW = 117;
    localparam logic [NB-1:0] P = {2'b11, 252'h0644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001};

    logic          clk = 1'b0;
    logic          reset_n, s_valid, s_ready, m_valid, m_ready;
    logic          g_reset, g_enable, g_done, busy, err_noncanon;
    logic [NB-1:0] s_data, m_data, g_in_state, g_out_state;
    logic [2:0]    g_wr, g_rd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    griffin_stream_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .g_reset(g_reset), .g_enable(g_enable), .g_wr(g_wr), .g_rd(g_rd),
        .g_in_state(g_in_state), .g_out_state(g_out_state), .g_done(g_done),
        .busy(busy), .err_noncanon(err_noncanon)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Core model: one word FIFO per lane, echoes written words back on read.
    logic [NB-1:0] q0[$], q1[$], q2[$];
    int en_cnt, hold_cnt, done_delay, done_hold;
    always @(posedge clk) begin
        if (g_reset) begin
            q0.delete(); q1.delete(); q2.delete();
            en_cnt = 0; hold_cnt = 0;
            g_done      <= 1'b0;
            g_out_state <= '0;
        end else begin
            if (g_wr[0]) q0.push_back(g_in_state);
            if (g_wr[1]) q1.push_back(g_in_state);
            if (g_wr[2]) q2.push_back(g_in_state);
            if (g_rd[0]) g_out_state <= (q0.size() > 0) ? q0.pop_front() : '0;
            if (g_rd[1]) g_out_state <= (q1.size() > 0) ? q1.pop_front() : '0;
            if (g_rd[2]) g_out_state <= (q2.size() > 0) ? q2.pop_front() : '0;
            if (g_enable) en_cnt++;
            if (en_cnt > done_delay && hold_cnt < done_hold) begin
                g_done <= 1'b1;
                hold_cnt++;
            end else begin
                g_done <= 1'b0;
            end
        end
    end

    // Monitor: records every transfer and tracks protocol rules per cycle.
    logic [NB-1:0] wr_dat_q[$], out_q[$];
    int   wr_oh_q[$], rd_lane_q[$];
    int   cyc = 0, hs_cnt, outst = 0, v_excl, v_full, v_en, v_err, greset_cnt;
    int   en_rises, hs_at_rise, en_fall_cyc, first_mv_cyc, first_pop_cyc, last_pop_cyc;
    logic prev_en = 1'b0, prev_done = 1'b0, exp_err = 1'b0;
    bit   mon_pop;

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            exp_err = 1'b0; prev_en = 1'b0; prev_done = 1'b0; outst = 0;
        end else begin
            if (err_noncanon !== exp_err) v_err++;
            if ((g_wr != 0 && g_rd != 0) || !$onehot0(g_wr) || !$onehot0(g_rd)) v_excl++;
            if (g_reset) greset_cnt++;
            if (s_valid && s_ready) begin
                hs_cnt++;
`ifdef CANON_CHECK_EN
                if (s_data >= P) exp_err = 1'b1;
`endif
            end
            if (g_wr != 0) begin
                wr_oh_q.push_back(int'(g_wr));
                wr_dat_q.push_back(g_in_state);
            end
            mon_pop = m_valid && m_ready;
            if (g_rd != 0) begin
                if (outst - int'(mon_pop) >= 2) v_full++;
                outst++;
                rd_lane_q.push_back(g_rd[2] ? 2 : (g_rd[1] ? 1 : 0));
            end
            if (mon_pop) begin
                out_q.push_back(m_data);
                outst--;
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
            end
            if (m_valid && first_mv_cyc < 0) first_mv_cyc = cyc;
            if (g_enable && !prev_en) begin en_rises++; hs_at_rise = hs_cnt; end
            if (!g_enable && prev_en) en_fall_cyc = cyc;
            if (prev_done && prev_en && g_enable) v_en++;
            prev_en = g_enable;
            prev_done = g_done;
        end
    end

    task automatic clear_mon();
        wr_dat_q.delete(); out_q.delete(); wr_oh_q.delete(); rd_lane_q.delete();
        hs_cnt = 0; v_excl = 0; v_full = 0; v_en = 0; v_err = 0; greset_cnt = 0;
        en_rises = 0; hs_at_rise = -1; en_fall_cyc = -1;
        first_mv_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1;
    endtask

    logic [NB-1:0] data_v [NW];

    function automatic logic [NB-1:0] rand_word();
        logic [255:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return {2'b00, t[251:0]};
    endfunction

    task automatic fill(input bit rnd);
        for (int i = 0; i < NW; i++) data_v[i] = rnd ? rand_word() : NB'(i + 1);
    endtask

    // gap: 0 back-to-back, 1 s_valid low every 3rd cycle, 2 random gaps
    task automatic feed(input int n, input int gap);
        int idx = 0;
        int c = 0;
        bit hs;
        while (idx < n && c < 4000) begin
            s_valid = !(gap == 1 && c % 3 == 2) && !(gap == 2 && $urandom_range(0, 3) == 0);
            s_data  = data_v[idx];
            @(negedge clk);
            hs = s_valid && s_ready;
            @(posedge clk); #1;
            if (hs) idx++;
            c++;
        end
        s_valid = 1'b0;
        check("feed_accepted", idx, n);
    endtask

    // bp: 0 always ready, 1 pattern 1,0,0,1, 2 random
    task automatic drain(input int bp);
        int c = 0;
        while (out_q.size() < NW && c < 6000) begin
            case (bp)
                0:       m_ready = 1'b1;
                1:       m_ready = (c % 4 == 0) || (c % 4 == 3);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            @(posedge clk); #1;
            c++;
        end
        m_ready = 1'b1;
    endtask

    task automatic run_batch(input int gap, input int bp, input int dd, input int dh, input bit chk_rate);
        int c = 0;
        clear_mon();
        done_delay = dd;
        done_hold  = dh;
        fork
            feed(NW, gap);
            drain(bp);
        join
        while (busy && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_drain", busy, 1'b0);
        check("clear_pulses", greset_cnt, 1);
        check("wr_count", wr_oh_q.size(), NW);
        for (int i = 0; i < NW && i < wr_oh_q.size(); i++) begin
            check("wr_onehot", wr_oh_q[i], 1 << (i / 39));
            check("wr_data", wr_dat_q[i], data_v[i]);
        end
        check("rd_count", rd_lane_q.size(), NW);
        for (int i = 0; i < NW && i < rd_lane_q.size(); i++)
            check("rd_lane_order", rd_lane_q[i], i / 39);
        check("out_count", out_q.size(), NW);
        for (int i = 0; i < NW && i < out_q.size(); i++)
            check("out_data", out_q[i], data_v[i]);
        check("run_entries", en_rises, 1);
        check("run_after_117", hs_at_rise, NW);
        check("wr_rd_exclusive", v_excl, 0);
        check("rd_when_full", v_full, 0);
        check("enable_after_done", v_en, 0);
        check("err_flag_timing", v_err, 0);
        if (chk_rate) begin
            check("drain_startup", first_mv_cyc - en_fall_cyc, 2);
            check("drain_rate", last_pop_cyc - first_pop_cyc, NW - 1);
        end
    endtask

    typedef struct {
        logic       rst_n;
        logic       sv;
        logic [7:0] d;
        logic       e_ready;
        logic       e_greset;
        logic       e_busy;
        logic [2:0] e_wr;
        logic [7:0] e_in;
    } vec_t;
    vec_t tbl [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 3'b000, 8'd0};
        tbl[1] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 3'b000, 8'd0};
        tbl[2] = '{1'b1, 1'b1, 8'd5, 1'b0, 1'b1, 1'b1, 3'b000, 8'd0};
        tbl[3] = '{1'b1, 1'b1, 8'd5, 1'b1, 1'b0, 1'b1, 3'b000, 8'd0};
        tbl[4] = '{1'b1, 1'b1, 8'd7, 1'b1, 1'b0, 1'b1, 3'b001, 8'd7};
        tbl[5] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 3'b000, 8'd7};
        tbl[6] = '{1'b1, 1'b1, 8'd9, 1'b1, 1'b0, 1'b1, 3'b001, 8'd9};
        tbl[7] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 3'b000, 8'd0};

        m_ready = 1'b1; s_valid = 1'b0; s_data = '0; reset_n = 1'b0;
        done_delay = 2; done_hold = 1;
        clear_mon();

        for (int k = 0; k < 8; k++) begin
            reset_n = tbl[k].rst_n;
            s_valid = tbl[k].sv;
            s_data  = NB'(tbl[k].d);
            @(posedge clk);
            @(negedge clk);
            check("vec_s_ready", s_ready, tbl[k].e_ready);
            check("vec_g_reset", g_reset, tbl[k].e_greset);
            check("vec_busy", busy, tbl[k].e_busy);
            check("vec_g_wr", g_wr, tbl[k].e_wr);
            check("vec_g_in_state", g_in_state, NB'(tbl[k].e_in));
        end
        check("vec_reset_m_valid", m_valid, 1'b0);
        check("vec_reset_g_enable", g_enable, 1'b0);
        reset_n = 1'b1;
        s_valid = 1'b0;
        @(posedge clk); #1;

        fill(1'b0);
        run_batch(0, 0, 2, 1, 1'b1);

        fill(1'b1);
        run_batch(1, 1, 0, 5, 1'b0);

        fill(1'b1);
        data_v[60] = P - 1;
        run_batch(2, 2, $urandom_range(0, 6), 2, 1'b0);
        check("err_at_p_minus_1", err_noncanon, 1'b0);

        // Abort a batch after 50 accepted words, then restart cleanly.
        fill(1'b1);
        clear_mon();
        done_delay = 2; done_hold = 1;
        feed(50, 0);
        @(negedge clk); #1;
        check("partial_wr_count", wr_oh_q.size(), 50);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_ctrl_outputs", {s_ready, m_valid, g_enable, g_wr, g_rd, busy, g_reset}, 11'b000_000_000_0_1);
        check("rst_g_in_state", g_in_state, '0);
        check("rst_m_data", m_data, '0);
        check("rst_err", err_noncanon, 1'b0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        fill(1'b1);
        data_v[60] = P;
        run_batch(0, 1, 3, 1, 1'b0);

        fill(1'b1);
        run_batch(2, 2, 4, 2, 1'b0);

`ifdef CANON_CHECK_EN
        check("err_sticky_final", err_noncanon, 1'b1);
`else
        check("err_tied_low", err_noncanon, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
